// File: rtl/poly_ctrl_pkg.sv
// Shared types and encodings for the Horner-rule polynomial controller.
// Holds the FSM state encoding, the datapath select encodings and the
// state-to-strobe decode used by poly_horner_ctrl.
package poly_ctrl_pkg;

    // Controller states: one pass is LOADX, INIT, (MUL, ADD) x DEGREE, DONE
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADX = 3'd1,
        INIT  = 3'd2,
        MUL   = 3'd3,
        ADD   = 3'd4,
        DONE  = 3'd5
    } state_t;

    // ALU operation select (operand A is always ACC)
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_MUL = 1'b1;

    // ACC load source select
    localparam logic SRC_ALU  = 1'b0;
    localparam logic SRC_COEF = 1'b1;

    // ALU operand B select
    localparam logic BSEL_X    = 1'b0;
    localparam logic BSEL_COEF = 1'b1;

    // Single-bit control strobes towards the datapath, bundled so the
    // whole decode can be defaulted to zero in one assignment.
    typedef struct packed {
        logic busy;
        logic done;
        logic load_x;
        logic load_acc;
        logic acc_src;
        logic alu_op;
        logic alu_b_sel;
    } ctrl_t;

    // States during which an evaluation is in flight (and may be aborted)
    function automatic logic is_busy_state(input state_t s);
        return (s == LOADX) || (s == INIT) || (s == MUL) || (s == ADD);
    endfunction

    // Moore decode of the single-bit strobes; anything not named is zero.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        c.busy = is_busy_state(s);
        case (s)
            LOADX: begin
                c.load_x = 1'b1;
            end
            INIT: begin
                c.load_acc = 1'b1;
                c.acc_src  = SRC_COEF;
            end
            MUL: begin
                c.load_acc  = 1'b1;
                c.acc_src   = SRC_ALU;
                c.alu_op    = ALU_MUL;
                c.alu_b_sel = BSEL_X;
            end
            ADD: begin
                c.load_acc  = 1'b1;
                c.acc_src   = SRC_ALU;
                c.alu_op    = ALU_ADD;
                c.alu_b_sel = BSEL_COEF;
            end
            DONE: begin
                c.done = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/poly_idx_counter.sv
// Coefficient index down-counter for the Horner controller.
// Loads a start value, decrements on request and reports zero.
// It saturates at zero: a decrement request at zero is ignored, so the
// index can never wrap to the top of its range.
module poly_idx_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Index register: reset clears, load has priority over decrement
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    // Zero flag tells the FSM the constant term has just been added
    always_comb begin
        zero = (count == '0);
    end

endmodule

// File: rtl/poly_horner_ctrl.sv
// Horner-rule polynomial evaluation controller.
// Sequences an external datapath (X register, ACC register, shared ALU,
// coefficient mux/ROM) to compute
//     y = c[D]*x^D + ... + c[1]*x + c[0]
// as ACC = c[D]; then repeatedly ACC = ACC*X; ACC = ACC + c[k] for
// k = D-1 down to 0. Handshake is start/busy/done.
// Optional build macro POLY_CTRL_ABORT_EN adds an abort input that drops
// an in-flight evaluation back to IDLE without a done pulse.
module poly_horner_ctrl #(
    parameter int DEGREE = 2,
    parameter int IDX_W  = $clog2(DEGREE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef POLY_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             load_x,
    output logic             load_acc,
    output logic             acc_src,
    output logic             alu_op,
    output logic             alu_b_sel,
    output logic [IDX_W-1:0] coef_idx
);

    import poly_ctrl_pkg::*;

    // Leading coefficient index, and the first index used by an ADD step
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(DEGREE);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(DEGREE - 1);

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] k;
    logic             k_zero;
    logic             k_load;
    logic             k_dec;
    ctrl_t            ctrl;

    // Index counter k: loaded in INIT, stepped down after each non-final ADD
    poly_idx_counter #(
        .WIDTH (IDX_W)
    ) u_idx_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (k_load),
        .load_value (IDX_FIRST),
        .dec        (k_dec),
        .count      (k),
        .zero       (k_zero)
    );

    // State register; a synchronous reset abandons any evaluation silently
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only looked at in IDLE so it is never queued
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = LOADX;
                end
            end
            LOADX: begin
                next_state = INIT;
            end
            INIT: begin
                next_state = MUL;
            end
            MUL: begin
                next_state = ADD;
            end
            ADD: begin
                if (k_zero) begin
                    next_state = DONE;
                end else begin
                    next_state = MUL;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
`ifdef POLY_CTRL_ABORT_EN
        if (abort && is_busy_state(state)) begin
            next_state = IDLE;
        end
`endif
    end

    // Counter control; the decrement is skipped at zero so k never wraps
    always_comb begin
        k_load = 1'b0;
        k_dec  = 1'b0;
        if (state == INIT) begin
            k_load = 1'b1;
        end
        if ((state == ADD) && !k_zero) begin
            k_dec = 1'b1;
        end
    end

    // Moore output decode from the registered state and k only
    always_comb begin
        ctrl     = decode_ctrl(state);
        coef_idx = '0;
        if (state == INIT) begin
            coef_idx = IDX_TOP;
        end else if (state == ADD) begin
            coef_idx = k;
        end
    end

    // Fan the decoded strobe bundle out onto the individual ports
    always_comb begin
        busy      = ctrl.busy;
        done      = ctrl.done;
        load_x    = ctrl.load_x;
        load_acc  = ctrl.load_acc;
        acc_src   = ctrl.acc_src;
        alu_op    = ctrl.alu_op;
        alu_b_sel = ctrl.alu_b_sel;
    end

endmodule

// File: tb/tb_poly_horner_ctrl.sv
// Directed self-checking bench for poly_horner_ctrl.
// Three controllers (DEGREE 2, 4 and 1) each drive a small behavioural
// datapath; outputs are sampled on the falling edge, inputs driven there.
// Abort scenarios are included when POLY_CTRL_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_poly_horner_ctrl;

    // Strobe patterns, bit order {busy, done, load_x, load_acc, acc_src, alu_op, alu_b_sel}
    localparam logic [6:0] C_IDLE  = 7'b0000000;
    localparam logic [6:0] C_LOADX = 7'b1010000;
    localparam logic [6:0] C_INIT  = 7'b1001100;
    localparam logic [6:0] C_MUL   = 7'b1001010;
    localparam logic [6:0] C_ADD   = 7'b1001001;
    localparam logic [6:0] C_DONE  = 7'b0100000;

    logic clk = 1'b0;
    logic reset;
    logic start2, start4, start1;
`ifdef POLY_CTRL_ABORT_EN
    logic abort2, abort4, abort1;
`endif

    logic busy2, done2, load_x2, load_acc2, acc_src2, alu_op2, alu_b_sel2;
    logic busy4, done4, load_x4, load_acc4, acc_src4, alu_op4, alu_b_sel4;
    logic busy1, done1, load_x1, load_acc1, acc_src1, alu_op1, alu_b_sel1;
    logic [1:0] coef_idx2;
    logic [2:0] coef_idx4;
    logic [0:0] coef_idx1;
    logic [10:0] obs2, obs4, obs1;

    int x_in2, x_reg2, acc2;
    int x_in4, x_reg4, acc4;
    int x_in1, x_reg1, acc1;
    int coef2 [0:2];
    int coef4 [0:4];
    int coef1 [0:1];

    int tests_run;
    int tests_failed;
    int cycle, done_at, init_idx, mul_cnt, add_cnt, low_len, seen_busy, stray;
    logic [15:0] add_seq;
    logic [10:0] trace2 [0:7];
    int done_q[$];
    int low_q[$];

    always #5 clk = ~clk;

    assign obs2 = {busy2, done2, load_x2, load_acc2, acc_src2, alu_op2, alu_b_sel2, 2'b00, coef_idx2};
    assign obs4 = {busy4, done4, load_x4, load_acc4, acc_src4, alu_op4, alu_b_sel4, 1'b0, coef_idx4};
    assign obs1 = {busy1, done1, load_x1, load_acc1, acc_src1, alu_op1, alu_b_sel1, 3'b000, coef_idx1};

    poly_horner_ctrl #(.DEGREE(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2),
`ifdef POLY_CTRL_ABORT_EN
        .abort(abort2),
`endif
        .busy(busy2), .done(done2), .load_x(load_x2), .load_acc(load_acc2),
        .acc_src(acc_src2), .alu_op(alu_op2), .alu_b_sel(alu_b_sel2), .coef_idx(coef_idx2)
    );

    poly_horner_ctrl #(.DEGREE(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4),
`ifdef POLY_CTRL_ABORT_EN
        .abort(abort4),
`endif
        .busy(busy4), .done(done4), .load_x(load_x4), .load_acc(load_acc4),
        .acc_src(acc_src4), .alu_op(alu_op4), .alu_b_sel(alu_b_sel4), .coef_idx(coef_idx4)
    );

    poly_horner_ctrl #(.DEGREE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1),
`ifdef POLY_CTRL_ABORT_EN
        .abort(abort1),
`endif
        .busy(busy1), .done(done1), .load_x(load_x1), .load_acc(load_acc1),
        .acc_src(acc_src1), .alu_op(alu_op1), .alu_b_sel(alu_b_sel1), .coef_idx(coef_idx1)
    );

    // Behavioural datapath for each controller: X register, ACC register, ALU, coefficient ROM
    always @(posedge clk) begin
        if (load_x2) x_reg2 <= x_in2;
        if (load_acc2) acc2 <= acc_src2 ? coef2[coef_idx2] :
            (alu_op2 ? acc2 * (alu_b_sel2 ? coef2[coef_idx2] : x_reg2)
                     : acc2 + (alu_b_sel2 ? coef2[coef_idx2] : x_reg2));
        if (load_x4) x_reg4 <= x_in4;
        if (load_acc4) acc4 <= acc_src4 ? coef4[coef_idx4] :
            (alu_op4 ? acc4 * (alu_b_sel4 ? coef4[coef_idx4] : x_reg4)
                     : acc4 + (alu_b_sel4 ? coef4[coef_idx4] : x_reg4));
        if (load_x1) x_reg1 <= x_in1;
        if (load_acc1) acc1 <= acc_src1 ? coef1[coef_idx1] :
            (alu_op1 ? acc1 * (alu_b_sel1 ? coef1[coef_idx1] : x_reg1)
                     : acc1 + (alu_b_sel1 ? coef1[coef_idx1] : x_reg1));
    end

    function automatic logic [10:0] ev(input logic [6:0] ctl, input int idx);
        return {ctl, 4'(idx)};
    endfunction

    task automatic check_output(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
                   tag, observed, observed, expected, expected);
        end
    endtask

    // Pulse one start on the DEGREE=2 controller; returns at the LOADX cycle
    task automatic apply_stimulus();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset  = 1'b1;
        start2 = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
`ifdef POLY_CTRL_ABORT_EN
        abort2 = 1'b0;
        abort4 = 1'b0;
        abort1 = 1'b0;
`endif
        // c[2]=3, c[1]=2, c[0]=1, x=5: 3*25 + 2*5 + 1 = 86
        x_in2 = 5;
        coef2 = '{1, 2, 3};
        // c[4..0] = 1,2,3,4,5, x=2: 16 + 16 + 12 + 8 + 5 = 57
        x_in4 = 2;
        coef4 = '{5, 4, 3, 2, 1};
        // c[0]=4, c[1]=9, x=7: 9*7 + 4 = 67
        x_in1 = 7;
        coef1 = '{4, 9};
        trace2 = '{ev(C_LOADX, 0), ev(C_INIT, 2), ev(C_MUL, 0), ev(C_ADD, 1),
                   ev(C_MUL, 0), ev(C_ADD, 0), ev(C_DONE, 0), ev(C_IDLE, 0)};

        repeat (2) @(negedge clk);
        check_output("reset_d2", int'(obs2), 0);
        check_output("reset_d4", int'(obs4), 0);
        check_output("reset_d1", int'(obs1), 0);
        reset = 1'b0;
        @(negedge clk);

        // DEGREE=2 cycle-by-cycle trace
        apply_stimulus();
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("d2_cycle%0d", i), int'(obs2), int'(trace2[i]));
            if (i == 6) check_output("d2_acc", acc2, 86);
            @(negedge clk);
        end

        // DEGREE=4 run: index sequence, latency and result
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cycle = 0; done_at = -1; init_idx = -1; add_seq = '0;
        while (cycle < 40 && done_at < 0) begin
            if (obs4[10:4] == C_INIT) init_idx = int'(coef_idx4);
            if (obs4[10:4] == C_ADD) add_seq = {add_seq[11:0], 1'b0, coef_idx4};
            if (done4) done_at = cycle;
            else begin
                @(negedge clk);
                cycle++;
            end
        end
        check_output("d4_init_idx", init_idx, 4);
        check_output("d4_add_seq", int'(add_seq), 16'h3210);
        check_output("d4_done_cycle", done_at, 10);
        check_output("d4_acc", acc4, 57);
        @(negedge clk);
        check_output("d4_idle_after", int'(obs4), 0);

        // DEGREE=1 run: one MUL, one ADD
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cycle = 0; done_at = -1; mul_cnt = 0; add_cnt = 0;
        while (cycle < 40 && done_at < 0) begin
            if (obs1[10:4] == C_MUL) mul_cnt++;
            if (obs1[10:4] == C_ADD) add_cnt++;
            if (done1) done_at = cycle;
            else begin
                @(negedge clk);
                cycle++;
            end
        end
        check_output("d1_done_cycle", done_at, 4);
        check_output("d1_acc", acc1, 67);
        check_output("d1_mul_count", mul_cnt, 1);
        check_output("d1_add_count", add_cnt, 1);
        @(negedge clk);

        // start held high for 30 cycles on DEGREE=2
        start2 = 1'b1;
        low_len = 0; seen_busy = 0;
        done_q.delete();
        low_q.delete();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done2) done_q.push_back(i);
            if (!busy2) low_len++;
            else begin
                if (seen_busy != 0 && low_len > 0) low_q.push_back(low_len);
                low_len = 0;
                seen_busy = 1;
            end
        end
        start2 = 1'b0;
        check_output("hold_done_count", done_q.size(), 3);
        for (int i = 1; i < done_q.size(); i++)
            check_output($sformatf("hold_done_gap%0d", i), done_q[i] - done_q[i-1], 8);
        check_output("hold_gap_count", low_q.size(), 3);
        foreach (low_q[i])
            check_output($sformatf("hold_busy_low%0d", i), low_q[i], 2);
        cycle = 0;
        while (!done2 && cycle < 20) begin
            @(negedge clk);
            cycle++;
        end
        check_output("hold_drain_done", int'(done2), 1);
        check_output("hold_drain_acc", acc2, 86);
        @(negedge clk);
        check_output("hold_drain_idle", int'(obs2), 0);

        // Reset during the second MUL, then a fresh evaluation with x=3 (9*3+... = 34)
        apply_stimulus();
        repeat (4) @(negedge clk);
        check_output("rst_second_mul", int'(obs2), int'(ev(C_MUL, 0)));
        reset = 1'b1;
        @(negedge clk);
        check_output("rst_outputs_zero", int'(obs2), 0);
        reset = 1'b0;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (done2 || load_acc2 || load_x2) stray = 1;
        end
        check_output("rst_no_activity", stray, 0);
        x_in2 = 3;
        apply_stimulus();
        cycle = 0; done_at = -1;
        while (cycle < 40 && done_at < 0) begin
            if (done2) done_at = cycle;
            else begin
                @(negedge clk);
                cycle++;
            end
        end
        check_output("rst_rerun_done_cycle", done_at, 6);
        check_output("rst_rerun_acc", acc2, 34);
        @(negedge clk);

`ifdef POLY_CTRL_ABORT_EN
        // Abort in the first ADD, then start+abort together in IDLE
        x_in2 = 5;
        apply_stimulus();
        repeat (3) @(negedge clk);
        check_output("abort_first_add", int'(obs2), int'(ev(C_ADD, 1)));
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        check_output("abort_idle", int'(obs2), 0);
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (done2 || busy2) stray = 1;
        end
        check_output("abort_no_done", stray, 0);
        start2 = 1'b1;
        abort2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        abort2 = 1'b0;
        check_output("abort_start_wins", int'(obs2), int'(ev(C_LOADX, 0)));
        cycle = 0;
        while (!done2 && cycle < 40) begin
            @(negedge clk);
            cycle++;
        end
        check_output("abort_rerun_done", int'(done2), 1);
        check_output("abort_rerun_acc", acc2, 86);
        @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
